// File: rtl/core_pipe_stage_pkg.sv
// rtl/core_pipe_stage_pkg.sv - shared state encodings, payload widths and bubble constants for core pipeline stages
package core_pipe_stage_pkg;

    // Stage fill state; the encoding equals the number of held entries.
    localparam int         PIPE_STATE_W     = 2;
    localparam logic [1:0] PIPE_STATE_EMPTY = 2'd0;
    localparam logic [1:0] PIPE_STATE_ONE   = 2'd1;
    localparam logic [1:0] PIPE_STATE_FULL  = 2'd2;

    localparam int PIPE_OCC_W = 2;

    // Instruction word and the canonical NOP (addi x0, x0, 0) used as bubble.
    localparam int          INST_W   = 32;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Packed payload widths of the individual stage registers.
    localparam int IFID_PAYLOAD_WIDTH  = 32 + INST_W;                 // pc, inst
    localparam int IDEX_PAYLOAD_WIDTH  = 32 + 32 + 32 + 32 + 5 + 8;   // pc, rs1, rs2, imm, rd, ctrl
    localparam int EXMEM_PAYLOAD_WIDTH = 32 + 32 + 5 + 4;             // alu, store data, rd, ctrl

    // IF/ID bubble: pc cleared, instruction replaced by NOP.
    localparam logic [IFID_PAYLOAD_WIDTH-1:0] IFID_BUBBLE = {32'h0, INST_NOP};

    function automatic logic [PIPE_OCC_W-1:0] pipe_occ(input logic [PIPE_STATE_W-1:0] st);
        case (st)
            PIPE_STATE_ONE:  pipe_occ = 2'd1;
            PIPE_STATE_FULL: pipe_occ = 2'd2;
            default:         pipe_occ = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/core_pipe_stage_sat_cnt.sv
// rtl/core_pipe_stage_sat_cnt.sv - gen_sat_cnt: parametrised saturating up-counter
// Ports:
//   clk, rst     clock, synchronous active-high reset (clears the count)
//   clr_in       synchronous clear
//   inc_in       increment enable; the count holds at all-ones
//   cnt_out      current count
module gen_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_in,
    input  logic             inc_in,
    output logic [WIDTH-1:0] cnt_out
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    always_ff @(posedge clk) begin
        if (rst || clr_in) begin
            cnt_out <= '0;
        end else if (inc_in && (cnt_out != CNT_MAX)) begin
            cnt_out <= cnt_out + CNT_ONE;
        end
    end

endmodule

// File: rtl/core_pipe_stage.sv
// rtl/core_pipe_stage.sv - valid/ready pipeline stage register with hold, flush, optional skid entry and stall counter
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   hold_in                         freeze: no transfer on either side, contents kept
//   flush_in                        drop all entries, show the bubble next cycle
//   up_valid_in/up_ready_out/up_data_in   upstream handshake and payload
//   dn_valid_out/dn_ready_in/dn_data_out  downstream handshake and payload (RST_VALUE when empty)
//   occupancy_out                   entries held (0..2)
//   stall_cnt_out                   saturating count of occupied cycles without a downstream transfer
module core_pipe_stage
    import core_pipe_stage_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RST_VALUE  = {DATA_WIDTH{1'b0}},
    parameter int                    SKID       = 1,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold_in,
    input  logic                  flush_in,
    input  logic                  up_valid_in,
    output logic                  up_ready_out,
    input  logic [DATA_WIDTH-1:0] up_data_in,
    output logic                  dn_valid_out,
    input  logic                  dn_ready_in,
    output logic [DATA_WIDTH-1:0] dn_data_out,
    output logic [1:0]            occupancy_out,
    output logic [CNT_WIDTH-1:0]  stall_cnt_out
);

    localparam bit SKID_EN = (SKID != 0);

    logic [PIPE_STATE_W-1:0] state_q, state_d;
    logic [DATA_WIDTH-1:0]   main_q, main_d;
    logic [DATA_WIDTH-1:0]   skid_q, skid_d;
    logic                    up_xfer;
    logic                    dn_xfer;
    logic                    stall_inc;

    // With the skid entry, ready depends only on registered state so it can be
    // driven straight from a flop; the single-entry variant must look through
    // dn_ready_in to keep one beat per cycle.
    always_comb begin
        up_ready_out = 1'b0;
        if (!hold_in && !flush_in && !rst) begin
            if (SKID_EN) begin
                up_ready_out = (state_q != PIPE_STATE_FULL);
            end else begin
                up_ready_out = (state_q == PIPE_STATE_EMPTY) || dn_ready_in;
            end
        end
    end

    assign dn_valid_out  = (state_q != PIPE_STATE_EMPTY) && !hold_in && !flush_in;
    assign dn_data_out   = main_q;
    assign occupancy_out = pipe_occ(state_q);

    assign up_xfer = up_valid_in && up_ready_out;
    assign dn_xfer = dn_valid_out && dn_ready_in;

    // main always holds the oldest entry; skid only ever holds the beat that
    // arrived while main was blocked.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_in) begin
            state_d = PIPE_STATE_EMPTY;
            main_d  = RST_VALUE;
            skid_d  = RST_VALUE;
        end else begin
            case (state_q)
                PIPE_STATE_EMPTY: begin
                    if (up_xfer) begin
                        state_d = PIPE_STATE_ONE;
                        main_d  = up_data_in;
                    end
                end
                PIPE_STATE_ONE: begin
                    if (up_xfer && dn_xfer) begin
                        main_d = up_data_in;
                    end else if (up_xfer) begin
                        state_d = PIPE_STATE_FULL;
                        skid_d  = up_data_in;
                    end else if (dn_xfer) begin
                        state_d = PIPE_STATE_EMPTY;
                        main_d  = RST_VALUE;
                    end
                end
                PIPE_STATE_FULL: begin
                    if (dn_xfer) begin
                        state_d = PIPE_STATE_ONE;
                        main_d  = skid_q;
                        skid_d  = RST_VALUE;
                    end
                end
                default: begin
                    state_d = PIPE_STATE_EMPTY;
                    main_d  = RST_VALUE;
                    skid_d  = RST_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PIPE_STATE_EMPTY;
            main_q  <= RST_VALUE;
            skid_q  <= RST_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Hold and flush cycles are not counted as stalls: the stage is being
    // steered from outside, not blocked by downstream.
    assign stall_inc = (state_q != PIPE_STATE_EMPTY) && !dn_xfer && !flush_in && !hold_in;

    gen_sat_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_in  (1'b0),
        .inc_in  (stall_inc),
        .cnt_out (stall_cnt_out)
    );

endmodule

// File: tb/tb_core_pipe_stage.sv
// tb/tb_core_pipe_stage.sv - scoreboard bench for core_pipe_stage, skid and single-entry variants side by side
module tb_core_pipe_stage;
    import core_pipe_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic        up_valid = 1'b0;
    logic [31:0] up_data = '0;
    logic        dn_ready = 1'b0;

    // index 1: SKID=1, 16-bit counter; index 0: SKID=0, 2-bit counter
    logic        up_ready [2];
    logic        dn_valid [2];
    logic [31:0] dn_data  [2];
    logic [1:0]  occ      [2];
    logic [15:0] stall16;
    logic [1:0]  stall2;

    logic [31:0] exp_q [2][$];
    int          stall_m [2];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    core_pipe_stage #(.DATA_WIDTH(32), .RST_VALUE(INST_NOP), .SKID(1), .CNT_WIDTH(16)) u_skid (
        .clk(clk), .rst(rst), .hold_in(hold), .flush_in(flush),
        .up_valid_in(up_valid), .up_ready_out(up_ready[1]), .up_data_in(up_data),
        .dn_valid_out(dn_valid[1]), .dn_ready_in(dn_ready), .dn_data_out(dn_data[1]),
        .occupancy_out(occ[1]), .stall_cnt_out(stall16)
    );

    core_pipe_stage #(.DATA_WIDTH(32), .RST_VALUE(INST_NOP), .SKID(0), .CNT_WIDTH(2)) u_noskid (
        .clk(clk), .rst(rst), .hold_in(hold), .flush_in(flush),
        .up_valid_in(up_valid), .up_ready_out(up_ready[0]), .up_data_in(up_data),
        .dn_valid_out(dn_valid[0]), .dn_ready_in(dn_ready), .dn_data_out(dn_data[0]),
        .occupancy_out(occ[0]), .stall_cnt_out(stall2)
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s[dut%0d] actual=%h required=%h at %0t", name, idx, act, req, $time);
        end
    endtask

    // Reference: a stage is a FIFO of capacity 2 (skid) or 1 (no skid) whose
    // head is visible downstream; the scoreboard queue is that FIFO.
    task automatic model_cycle(input int i);
        int          sz;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_data;
        logic [31:0] act_stall;
        int          stall_max;
        sz        = exp_q[i].size();
        stall_max = (i == 1) ? 65535 : 3;
        act_stall = (i == 1) ? {16'h0, stall16} : {30'h0, stall2};
        e_valid   = (sz > 0) && !hold && !flush;
        e_data    = (sz > 0) ? exp_q[i][0] : INST_NOP;
        if (rst || hold || flush) e_ready = 1'b0;
        else if (i == 1)          e_ready = (sz < 2);
        else                      e_ready = (sz == 0) || dn_ready;
        chk("up_ready", i, {31'h0, up_ready[i]}, {31'h0, e_ready});
        chk("dn_valid", i, {31'h0, dn_valid[i]}, {31'h0, e_valid});
        chk("dn_data", i, dn_data[i], e_data);
        chk("occupancy", i, {30'h0, occ[i]}, sz);
        chk("stall_cnt", i, act_stall, stall_m[i]);
        if (rst) begin
            exp_q[i].delete();
            stall_m[i] = 0;
        end else if (flush) begin
            exp_q[i].delete();
        end else begin
            if ((sz > 0) && !(e_valid && dn_ready) && !hold && stall_m[i] < stall_max)
                stall_m[i]++;
            if (e_ready && up_valid)
                exp_q[i].push_back(up_data);
        end
    endtask

    task automatic step(input logic r, input logic h, input logic f, input logic uv,
                        input logic [31:0] d, input logic dr);
        @(negedge clk);
        rst = r; hold = h; flush = f; up_valid = uv; up_data = d; dn_ready = dr;
        #2;
        model_cycle(1);
        model_cycle(0);
    endtask

    // Monitor: every beat the DUT hands downstream must be the oldest one the
    // stimulus side recorded as accepted.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #3;
            for (int i = 0; i < 2; i++) begin
                if (!rst && dn_valid[i] === 1'b1 && dn_ready) begin
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dn_beat[dut%0d] actual=%h required=none (unexpected beat)", i, dn_data[i]);
                    end else begin
                        e = exp_q[i].pop_front();
                        chk("dn_beat", i, dn_data[i], e);
                    end
                end
            end
        end
    end

    initial begin
        stall_m[0] = 0;
        stall_m[1] = 0;
        repeat (2) @(posedge clk);

        step(1, 0, 0, 0, 32'h0, 0);
        // streaming at full rate
        step(0, 0, 0, 1, 32'h11, 1);
        step(0, 0, 0, 1, 32'h22, 1);
        step(0, 0, 0, 1, 32'h33, 1);
        step(0, 0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 0, 32'h0, 1);
        // fill, stall, drain
        step(0, 0, 0, 1, 32'hA1, 0);
        step(0, 0, 0, 1, 32'hA2, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 32'h0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 32'h0, 1);
        // flush a full stage
        step(0, 0, 0, 1, 32'hB1, 0);
        step(0, 0, 0, 1, 32'hB2, 0);
        step(0, 0, 1, 1, 32'hBF, 0);
        step(0, 0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 0, 32'h0, 1);
        // hold with downstream ready
        step(0, 0, 0, 1, 32'hC1, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 1, 32'hCF, 1);
        step(0, 0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 0, 32'h0, 1);
        // long stall: saturates the 2-bit counter
        step(0, 0, 0, 1, 32'hE1, 0);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 0, 32'h0, 1);
        // continuous input with toggling downstream ready, then reset mid-stream
        for (int k = 0; k < 6; k++) step(0, 0, 0, 1, 32'hD1 + k, (k % 2) == 0);
        step(1, 0, 0, 1, 32'hDF, 1);
        step(0, 0, 0, 0, 32'h0, 0);
        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 9) < 7,
                 $urandom,
                 $urandom_range(0, 9) < 6);
        end
        step(0, 0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 0, 32'h0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_pipe_stage.md
Name: core_pipe_stage

Overview:
Parametrised pipeline-stage register that replaces the fixed per-field hold/default flop banks between core stages (IF/ID, ID/EX, EX/MEM).
- Carries one packed payload with a valid/ready handshake.
- Supports separate hold (freeze) and flush (bubble insert); drained or flushed entries read back the bubble value (e.g. NOP encoding).
- With SKID=1, a 2-entry skid buffer gives full throughput with up_ready_out registered. A saturating stall counter feeds perf monitoring.

Parameters:
DATA_WIDTH, 32, payload width in bits (packed stage fields)
RST_VALUE, {DATA_WIDTH{1'b0}}, bubble payload driven when the stage is empty, reset or flushed
SKID, 1, 1 = two-entry skid buffer with registered up_ready_out; 0 = single entry with pass-through ready
CNT_WIDTH, 16, width of the stall counter

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
hold_in  input  1  freeze stage: no transfer on either side, contents kept
flush_in  input  1  discard all entries, insert bubble
up_valid_in  input  1  upstream payload valid
up_ready_out  output  1  stage can accept
up_data_in  input  DATA_WIDTH  upstream payload
dn_valid_out  output  1  payload valid to downstream
dn_ready_in  input  1  downstream accepts
dn_data_out  output  DATA_WIDTH  payload (RST_VALUE when empty)
occupancy_out  output  2  entries held (0..2; max 1 when SKID=0)
stall_cnt_out  output  CNT_WIDTH  saturating count of cycles with an occupied stage and no downstream transfer

Behaviour:
- Reset state (rst=1 at a clk edge): state EMPTY, main=skid=RST_VALUE, dn_valid_out=0, occupancy_out=0, stall_cnt_out=0. up_ready_out=0 while rst is high.
- Transfers:
  - up_xfer = up_valid_in & up_ready_out.
  - dn_xfer = dn_valid_out & dn_ready_in.
  - Both are evaluated with hold_in and flush_in already folded in.
- hold_in=1: up_ready_out=0, dn_valid_out=0. State, main, skid and counter are all unchanged. dn_data_out keeps showing the main entry.
- flush_in=1 (priority over hold_in and both transfers):
  - up_ready_out=0 and dn_valid_out=0 that cycle.
  - Next cycle: state EMPTY, main=skid=RST_VALUE.
  - stall_cnt_out is not cleared and not incremented.
- SKID=1 states:
  - up_ready_out = (state != FULL) & !hold_in & !flush_in & !rst. This depends on registered state only, not on dn_ready_in.
  - EMPTY: up_xfer -> ONE, main <= up_data_in.
  - ONE, up_xfer only -> FULL, skid <= up_data_in.
  - ONE, dn_xfer only -> EMPTY, main <= RST_VALUE.
  - ONE, both up_xfer and dn_xfer -> ONE, main <= up_data_in.
  - FULL: up_xfer is impossible. dn_xfer -> ONE, main <= skid, skid <= RST_VALUE.
- SKID=0:
  - States are EMPTY/ONE only.
  - up_ready_out = !hold_in & !flush_in & !rst & (state==EMPTY | dn_ready_in). This is combinational through dn_ready_in.
  - Transitions are as for ONE above, with no FULL state.
- dn_valid_out = (state != EMPTY) & !hold_in & !flush_in.
- dn_data_out = main. Order is preserved: main always holds the oldest entry.
- Latency: 1 cycle from up_xfer to dn_valid_out. Throughput is 1 beat/cycle with continuous dn_ready_in, for both SKID values.
- stall_cnt_out:
  - Increments when state != EMPTY, dn_xfer=0, flush_in=0 and hold_in=0.
  - Saturates at all-ones with no wrap.
  - Cleared only by rst.
- Reset mid-transfer: rst overrides everything. Any in-flight beat is dropped and upstream sees up_ready_out=0.
- Simultaneous flush_in and up_valid_in: the upstream beat is not accepted (ready=0). Upstream must retry or be flushed itself.

Decomposition:
- defines.v gets:
  - PIPE_STATE_EMPTY/ONE/FULL (2-bit encoding)
  - PIPE_OCC width
  - per-stage packed-payload width macros (e.g. IDEX_PAYLOAD_WIDTH, the sum of the ID/EX field widths)
  - the INST_NOP-based bubble payload constant
- One natural sub-module: gen_sat_cnt (parametrised saturating counter with increment enable and synchronous clear), reusable by other perf counters.

Test Plan:
- Reset, then stream 0x11,0x22,0x33 with dn_ready_in=1 and SKID=1 -> each appears on dn_data_out exactly one cycle after its up_xfer; up_ready_out stays 1; stall_cnt_out=0.
- Push 0xA1,0xA2 with dn_ready_in=0 -> occupancy 2, up_ready_out=0, stall_cnt_out increments each cycle. Raise dn_ready_in -> outputs 0xA1 then 0xA2 in order, then dn_data_out=RST_VALUE.
- FULL stage (0xB1,0xB2), assert flush_in one cycle -> next cycle occupancy 0, dn_valid_out=0, dn_data_out=RST_VALUE (0x00000013 for the NOP bubble); stall count retained.
- ONE entry 0xC1, hold_in=1 for 3 cycles with dn_ready_in=1 -> dn_valid_out=0, up_ready_out=0, entry kept, counter frozen. Release hold -> 0xC1 delivered.
- CNT_WIDTH=2, stall 6 cycles -> stall_cnt_out reaches 3 and stays at 3.
- SKID=0, dn_ready_in toggling 1,0,1 with continuous input 0xD1.. -> up_ready_out follows dn_ready_in in the same cycle when occupied; no beat lost or duplicated. Assert rst mid-stream -> all outputs return to reset values the next cycle.
